// File: rtl/main_mem_port.sv
// main_mem_port: in-order store queue with load forwarding in front of a single-port synchronous word RAM
module main_mem_port #(
  parameter int ADDR_W = 16,
  parameter int SQ_DEPTH = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      main_mem_in_valid,
  input  logic [31:0]               main_mem_in_addr,
  input  logic [31:0]               main_mem_in_data,
  output logic                      main_mem_in_ready,
  input  logic                      main_mem_out_valid,
  input  logic [31:0]               main_mem_out_addr,
  output logic                      main_mem_out_ready,
  output logic [31:0]               main_mem_out_data,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata,
  output logic [$clog2(SQ_DEPTH):0] sq_count
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int QW = PW + 1;
  localparam int CW = $clog2(RAM_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, TURN} state_t;
  state_t state;
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] sq_addr [SQ_DEPTH];
  logic [31:0] sq_data [SQ_DEPTH];
  logic [ADDR_W-1:0] st_word, ld_word;
  logic [31:0] fwd;
  logic hit, accept, issue, enq, drain, done, unused_addr;
  assign st_word = main_mem_in_addr[ADDR_W+1:2];
  assign ld_word = main_mem_out_addr[ADDR_W+1:2];
  assign unused_addr = ^{main_mem_in_addr[31:ADDR_W+2], main_mem_in_addr[1:0],
                         main_mem_out_addr[31:ADDR_W+2], main_mem_out_addr[1:0]};
  assign accept = state == IDLE && main_mem_out_valid;
  assign issue = accept && !hit;
  assign drain = sq_count != '0 && !issue;
  assign enq = main_mem_in_valid && !main_mem_in_ready && sq_count != QW'(SQ_DEPTH) && !accept;
  assign done = state == WAIT && cnt == CW'(RAM_LATENCY - 1);
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = head;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head + PW'(i);
      if (QW'(i) < sq_count && sq_addr[idx] == ld_word) begin
        hit = 1'b1;
        fwd = sq_data[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      head <= '0;
      tail <= '0;
      sq_count <= '0;
      main_mem_in_ready <= 1'b0;
      main_mem_out_ready <= 1'b0;
      main_mem_out_data <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
    end else begin
      state <= issue ? ISSUE : accept ? RESP : state == ISSUE ? WAIT : done ? RESP :
               state == RESP ? TURN : state == TURN ? IDLE : state;
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      head <= head + PW'(drain);
      tail <= tail + PW'(enq);
      sq_count <= sq_count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
      main_mem_in_ready <= enq;
      main_mem_out_ready <= (accept && hit) || done;
      main_mem_out_data <= accept && hit ? fwd : done ? ram_rdata : main_mem_out_data;
      ram_en <= issue || drain;
      ram_we <= drain;
      ram_addr <= issue ? ld_word : drain ? sq_addr[head] : ram_addr;
      ram_wdata <= drain ? sq_data[head] : ram_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      sq_addr[tail] <= st_word;
      sq_data[tail] <= main_mem_in_data;
    end
  end
endmodule

// File: tb/tb_main_mem_port.sv
// tb_main_mem_port: directed scoreboard bench for main_mem_port with a behavioural RAM
module tb_main_mem_port;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset;
  logic main_mem_in_valid, main_mem_out_valid;
  logic [31:0] main_mem_in_addr, main_mem_in_data, main_mem_out_addr;
  logic main_mem_in_ready, main_mem_out_ready;
  logic [31:0] main_mem_out_data;
  logic ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [2:0] sq_count;
  int n_cmp = 0;
  int n_err = 0;
  int n_loads = 0;
  int rdy_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] gold [logic [15:0]];
  logic [31:0] mem [65536];
  bit [65535:0] wr_mask;
  logic [31:0] pipe [LAT];

  main_mem_port #(.ADDR_W(16), .SQ_DEPTH(4), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .main_mem_in_valid(main_mem_in_valid), .main_mem_in_addr(main_mem_in_addr),
    .main_mem_in_data(main_mem_in_data), .main_mem_in_ready(main_mem_in_ready),
    .main_mem_out_valid(main_mem_out_valid), .main_mem_out_addr(main_mem_out_addr),
    .main_mem_out_ready(main_mem_out_ready), .main_mem_out_data(main_mem_out_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .sq_count(sq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [15:0] w);
    return {16'hC0DE, w};
  endfunction

  always @(posedge clk) begin
    if (ram_en && !ram_we) begin
      pipe[0] <= wr_mask[ram_addr] ? mem[ram_addr] : init_word(ram_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_mask[ram_addr] <= 1'b1;
    end
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[LAT-1];

  always @(negedge clk) if (reset && main_mem_out_ready) rdy_cnt <= rdy_cnt + 1;

  function automatic logic [31:0] gold_rd(input logic [15:0] w);
    return gold.exists(w) ? gold[w] : init_word(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int n);
    main_mem_in_valid = 1'b1;
    main_mem_in_addr = a;
    main_mem_in_data = d;
    gold[a[17:2]] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!main_mem_in_ready && n < 40);
    check("store_ready", main_mem_in_ready, 1);
    check("sq_bound", sq_count <= 3'd4, 1);
    main_mem_in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input int lat, input int hold);
    logic [31:0] e;
    int n;
    main_mem_out_valid = 1'b1;
    main_mem_out_addr = a;
    exp_q.push_back(gold_rd(a[17:2]));
    n = 0;
    do begin @(negedge clk); n++; end while (!main_mem_out_ready && n < 40);
    check("load_ready", main_mem_out_ready, 1);
    e = exp_q.pop_front();
    check("load_data", main_mem_out_data, e);
    if (lat != 0) check("load_lat", n, lat);
    n_loads++;
    repeat (hold) @(negedge clk);
    main_mem_out_valid = 1'b0;
  endtask

  initial begin
    int n, rd0, r0;
    reset = 1'b1;
    main_mem_in_valid = 1'b0;
    main_mem_out_valid = 1'b0;
    main_mem_in_addr = '0;
    main_mem_in_data = '0;
    main_mem_out_addr = '0;
    #3 reset = 1'b0;
    #1;
    check("rst_in_ready", main_mem_in_ready, 0);
    check("rst_out_ready", main_mem_out_ready, 0);
    check("rst_out_data", main_mem_out_data, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_sq_count", sq_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    store(32'h000010f4, 32'h12345678, n);
    check("t1_store_lat", n, 1);
    check("t1_count1", sq_count, 1);
    @(negedge clk);
    check("t1_drain_en", ram_en, 1);
    check("t1_drain_we", ram_we, 1);
    check("t1_drain_addr", ram_addr, 16'h043d);
    check("t1_drain_data", ram_wdata, 32'h12345678);
    check("t1_count0", sq_count, 0);
    load(32'h000010f4, LAT + 2, 0);
    repeat (3) @(negedge clk);
    store(32'h00000f14, 32'h87654321, n);
    rd0 = rd_cnt;
    load(32'h00000f14, 1, 0);
    check("t2_no_read_a", rd_cnt, rd0);
    repeat (2) @(negedge clk);
    store(32'h00000f14, 32'h00000011, n);
    rd0 = rd_cnt;
    load(32'h00000f14, 1, 0);
    check("t2_no_read_b", rd_cnt, rd0);
    repeat (3) @(negedge clk);
    load(32'h00000f14, LAT + 2, 0);
    repeat (3) @(negedge clk);
    fork
      load(32'h00002000, LAT + 2, 0);
      for (int k = 0; k < 5; k++) store(32'h00003000 + 32'(4 * k), 32'hA0000000 + 32'(k), n);
    join
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) load(32'h00003000 + 32'(4 * k), 0, 0);
    repeat (3) @(negedge clk);
    fork
      begin
        store(32'h00004000, 32'h44444444, n);
        check("t4_store_after_load", n >= 2, 1);
      end
      load(32'h00004100, LAT + 2, 0);
    join
    repeat (3) @(negedge clk);
    load(32'h00004000, 0, 0);
    repeat (3) @(negedge clk);
    r0 = rdy_cnt;
    load(32'h00003004, 0, 1);
    repeat (6) @(negedge clk);
    check("t5_one_pulse", rdy_cnt, r0 + 1);
    main_mem_out_valid = 1'b1;
    main_mem_out_addr = 32'h00005000;
    @(negedge clk);
    main_mem_out_valid = 1'b0;
    main_mem_in_valid = 1'b1;
    main_mem_in_addr = 32'h000010f4;
    main_mem_in_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t6_queued", sq_count, 1);
    main_mem_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_in_ready", main_mem_in_ready, 0);
    check("t6_out_ready", main_mem_out_ready, 0);
    check("t6_out_data", main_mem_out_data, 0);
    check("t6_ram_en", ram_en, 0);
    check("t6_ram_we", ram_we, 0);
    check("t6_ram_addr", ram_addr, 0);
    check("t6_ram_wdata", ram_wdata, 0);
    check("t6_sq_count", sq_count, 0);
    r0 = rdy_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_stale_ready", rdy_cnt, r0);
    load(32'h000010f4, LAT + 2, 0);
    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("ready_pulses", rdy_cnt, r0 + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
